// File: rtl/cycle_sequencer.sv
`timescale 1ns/1ps
// PDP-8 major-state timing generator: FETCH -> [AUTO1 -> AUTO2] -> [IND] -> EXEC1..n.
// Outputs decode registered state/phase only. No backpressure: the sequence advances every clock while running.
module cycle_sequencer #(
  parameter int PHASES    = 4,
  parameter int STB_PHASE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       halt,
  input  logic       instIsIND,
  input  logic       instIsPPIND,
  input  logic [1:0] execLen,
  input  logic       irqRequest,
  output logic       ckFetch,
  output logic       ckAuto1,
  output logic       ckAuto2,
  output logic       ckInd,
  output logic       stbFetch,
  output logic       stbAuto1,
  output logic       stbAuto2,
  output logic       stbInd,
  output logic [2:0] ckExec,
  output logic [2:0] stbExec,
  output logic       irqOverride,
  output logic       running,
  output logic       instDone
);

  localparam int PW = (PHASES > 4) ? 3 : 2;
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);
  localparam logic [PW-1:0] STB  = PW'(STB_PHASE);

  typedef enum logic [2:0] {
    STOPPED, FETCH, AUTO1, AUTO2, IND, EXEC1, EXEC2, EXEC3
  } state_t;

  state_t        state, stateNext;
  logic [PW-1:0] phase;
  logic [1:0]    lenQ;
  logic          irqQ;
  logic          stepQ;

  logic          lastPhase;
  logic          finalExec;
  logic          boundary;
  logic          stopAtBoundary;
  logic          runStart;
  logic [1:0]    fetchLen;

  assign lastPhase      = (phase == LAST);
  assign finalExec      = (state == EXEC3) ||
                          (state == EXEC2 && lenQ <= 2'd2) ||
                          (state == EXEC1 && lenQ <= 2'd1);
  assign boundary       = lastPhase && finalExec;
  assign stopAtBoundary = halt || !run || stepQ;
  assign runStart       = run && !halt;
  // An interrupt-entry fetch is a forced JMS 0, which always takes two execute cycles.
  assign fetchLen       = irqQ ? 2'd2 : ((execLen == 2'd0) ? 2'd1 : execLen);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STOPPED;
      phase <= '0;
      lenQ  <= 2'd0;
      irqQ  <= 1'b0;
      stepQ <= 1'b0;
    end else begin
      state <= stateNext;
      phase <= (state == STOPPED || lastPhase) ? '0 : phase + PW'(1);
      if (state == STOPPED && !runStart && step)
        stepQ <= 1'b1;
      else if (boundary && stopAtBoundary)
        stepQ <= 1'b0;
      if (state == FETCH && lastPhase) begin
        lenQ <= fetchLen;
        irqQ <= 1'b0;
      end
      if (boundary)
        irqQ <= !stopAtBoundary && irqRequest;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      STOPPED: if (runStart || step) stateNext = FETCH;
      FETCH: if (lastPhase) begin
        if (irqQ)             stateNext = EXEC1;
        else if (instIsPPIND) stateNext = AUTO1;
        else if (instIsIND)   stateNext = IND;
        else                  stateNext = EXEC1;
      end
      AUTO1: if (lastPhase) stateNext = AUTO2;
      AUTO2: if (lastPhase) stateNext = IND;
      IND:   if (lastPhase) stateNext = EXEC1;
      EXEC1: if (lastPhase && lenQ > 2'd1) stateNext = EXEC2;
      EXEC2: if (lastPhase && lenQ > 2'd2) stateNext = EXEC3;
      EXEC3: ;
      default: stateNext = STOPPED;
    endcase
    if (boundary)
      stateNext = stopAtBoundary ? STOPPED : FETCH;
  end

  always_comb begin
    logic onData, onStb;
    onData      = (phase != '0);
    onStb       = (phase == STB);
    ckFetch     = 1'b0;
    ckAuto1     = 1'b0;
    ckAuto2     = 1'b0;
    ckInd       = 1'b0;
    stbFetch    = 1'b0;
    stbAuto1    = 1'b0;
    stbAuto2    = 1'b0;
    stbInd      = 1'b0;
    ckExec      = 3'b000;
    stbExec     = 3'b000;
    case (state)
      FETCH: begin ckFetch = onData; stbFetch = onStb; end
      AUTO1: begin ckAuto1 = onData; stbAuto1 = onStb; end
      AUTO2: begin ckAuto2 = onData; stbAuto2 = onStb; end
      IND:   begin ckInd   = onData; stbInd   = onStb; end
      EXEC1: begin ckExec[0] = onData; stbExec[0] = onStb; end
      EXEC2: begin ckExec[1] = onData; stbExec[1] = onStb; end
      EXEC3: begin ckExec[2] = onData; stbExec[2] = onStb; end
      default: ;
    endcase
    irqOverride = (state == FETCH) && irqQ;
    running     = (state != STOPPED);
    instDone    = boundary;
  end

endmodule
